// File: rtl/reorder_buffer_pkg.sv
// Shared ROB sizing and entry field widths, also used by the register file, RS and LSB.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int RD_ID_W       = 5;
    localparam int VALUE_W       = 32;
    localparam int TARGET_W      = 32;

    function automatic int rob_depth(input int width);
        return 1 << width;
    endfunction

    localparam int ROB_DEPTH_DEF = rob_depth(ROB_WIDTH_DEF);

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates at tail on issue, fills from the CDB,
// retires from head, and flushes everything on a mispredicted branch commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_signal,
    input  logic [RD_ID_W-1:0]   issue_rd_id,
    input  logic                 issue_is_branch,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rob_full,
    input  logic                 cdb_signal,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [VALUE_W-1:0]   cdb_value,
    input  logic                 cdb_mispredict,
    input  logic [TARGET_W-1:0]  cdb_target,
    input  logic [ROB_WIDTH-1:0] query_tag_1,
    input  logic [ROB_WIDTH-1:0] query_tag_2,
    output logic                 query_ready_1,
    output logic                 query_ready_2,
    output logic [VALUE_W-1:0]   query_value_1,
    output logic [VALUE_W-1:0]   query_value_2,
    output logic                 rob_commit_signal,
    output logic [VALUE_W-1:0]   commit_rd_value,
    output logic [RD_ID_W-1:0]   commit_rd_id,
    output logic [ROB_WIDTH-1:0] commit_rd_tag,
    output logic                 clear_signal,
    output logic [TARGET_W-1:0]  redirect_pc
);

    localparam int DEPTH = rob_depth(ROB_WIDTH);

    logic [ROB_WIDTH-1:0] head, tail;
    logic [ROB_WIDTH:0]   count;
    logic [DEPTH-1:0]     busy, ready, is_branch, mispredict;
    logic [RD_ID_W-1:0]   rd_id  [DEPTH];
    logic [VALUE_W-1:0]   value  [DEPTH];
    logic [TARGET_W-1:0]  target [DEPTH];

    logic take, do_commit, do_flush, do_issue, do_cdb;

    assign rob_full  = (count == (ROB_WIDTH+1)'(DEPTH));
    assign issue_tag = tail;

    // Nothing is accepted while stalled or during the flush pulse.
    assign take      = rdy_in & ~clear_signal;
    assign do_commit = take & busy[head] & ready[head];
    assign do_flush  = do_commit & is_branch[head] & mispredict[head];
    assign do_issue  = take & issue_signal & ~rob_full & ~do_flush;
    assign do_cdb    = take & cdb_signal & busy[cdb_tag];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            busy              <= '0;
            ready             <= '0;
            rob_commit_signal <= 1'b0;
            commit_rd_value   <= '0;
            commit_rd_id      <= '0;
            commit_rd_tag     <= '0;
            clear_signal      <= 1'b0;
            redirect_pc       <= '0;
        end else if (rdy_in) begin
            rob_commit_signal <= 1'b0;
            clear_signal      <= 1'b0;
            if (do_cdb)
                ready[cdb_tag] <= 1'b1;
            if (do_commit) begin
                busy[head]        <= 1'b0;
                rob_commit_signal <= (rd_id[head] != '0);
                commit_rd_id      <= rd_id[head];
                commit_rd_tag     <= head;
                commit_rd_value   <= value[head];
            end
            if (do_issue) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
            end
            if (do_flush) begin
                busy         <= '0;
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                clear_signal <= 1'b1;
                redirect_pc  <= target[head];
            end else begin
                head  <= head + ROB_WIDTH'(do_commit);
                tail  <= tail + ROB_WIDTH'(do_issue);
                count <= count + (ROB_WIDTH+1)'(do_issue) - (ROB_WIDTH+1)'(do_commit);
            end
        end
    end

    // Payload fields need no reset; busy/ready qualify them.
    always_ff @(posedge clk_in) begin
        if (do_cdb) begin
            value[cdb_tag]      <= cdb_value;
            mispredict[cdb_tag] <= cdb_mispredict;
            target[cdb_tag]     <= cdb_target;
        end
        if (do_issue) begin
            rd_id[tail]     <= issue_rd_id;
            is_branch[tail] <= issue_is_branch;
        end
    end

    always_comb begin
        query_ready_1 = busy[query_tag_1] & ready[query_tag_1];
        query_value_1 = value[query_tag_1];
        query_ready_2 = busy[query_tag_2] & ready[query_tag_2];
        query_value_2 = value[query_tag_2];
        if (cdb_signal && cdb_tag == query_tag_1) begin
            query_ready_1 = 1'b1;
            query_value_1 = cdb_value;
        end
        if (cdb_signal && cdb_tag == query_tag_2) begin
            query_ready_2 = 1'b1;
            query_value_2 = cdb_value;
        end
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter: ROB_WIDTH, default 4, sets tag width and a depth of 2^ROB_WIDTH entries.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  ready; when low, all state and outputs hold.
REQ-005 issue_signal  input  1  allocate one entry this cycle.
REQ-006 issue_rd_id  input  5  destination register of the issuing instruction (0 = none).
REQ-007 issue_is_branch  input  1  issuing instruction may mispredict.
REQ-008 issue_tag  output  ROB_WIDTH  tail index; drives rd_tag at the register file.
REQ-009 rob_full  output  1  high when count equals 2^ROB_WIDTH; combinational from count.
REQ-010 cdb_signal, cdb_tag[ROB_WIDTH], cdb_value[32], cdb_mispredict[1], cdb_target[32]  inputs  execution result broadcast.
REQ-011 query_tag_1, query_tag_2  input  ROB_WIDTH  operand lookup for issue.
REQ-012 query_ready_1/2 [1], query_value_1/2 [32]  outputs  combinational entry ready bit and value.
REQ-013 rob_commit_signal [1], commit_rd_value [32], commit_rd_id [5], commit_rd_tag [ROB_WIDTH]  registered outputs to the register file.
REQ-014 clear_signal [1], redirect_pc [32]  registered outputs; flush pulse and corrected fetch PC.

Function
REQ-015 Circular buffer with head, tail and count; head and tail wrap modulo 2^ROB_WIDTH.
REQ-016 Issue: when issue_signal, ~rob_full and ~clear_signal, write {rd_id, is_branch, ready=0} at tail; tail+1; issue_tag = tail before increment.
REQ-017 Issue when rob_full or clear_signal is high SHALL be ignored; full is evaluated on the pre-commit count.
REQ-018 CDB: when cdb_signal, the entry at cdb_tag gets value, mispredict and target, and ready=1; a CDB write to an empty slot is ignored.
REQ-019 Commit: when the head entry is busy and ready, on the edge set rob_commit_signal = (rd_id != 0), commit_rd_id/tag/value from the head; head+1; count-1; at most one commit per cycle.
REQ-020 Latency: CDB write at edge E makes the entry committable in the cycle after E; rob_commit_signal is visible after edge E+1 at the earliest.
REQ-021 rob_commit_signal SHALL be low in any cycle without a commit; commit data outputs may hold stale values.
REQ-022 Mispredict commit: with the head ready and mispredict=1, perform the REQ-019 commit, set clear_signal=1 and redirect_pc=target, and flush (head=tail=count=0, all entries not busy) at the same edge.
REQ-023 clear_signal is a one-cycle pulse; no issue, CDB write or commit is accepted during a cycle in which clear_signal is high.
REQ-024 Simultaneous issue and commit: count is unchanged; simultaneous CDB write to the head and commit check uses the old ready bit (commit occurs next cycle).
REQ-025 Query: query_ready_n = busy & ready of the entry at query_tag_n; when cdb_signal targets the same tag this cycle, forward cdb_value with ready=1.
REQ-026 rdy_in low: no issue, CDB, commit or flush takes effect, and registered outputs keep their values.

Reset
REQ-027 On rst_in: head=tail=count=0 and all entries not busy; rob_commit_signal=0, clear_signal=0, commit_rd_value=0, commit_rd_id=0, commit_rd_tag=0, redirect_pc=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-029 The shared package holds the ROB_WIDTH default, the ROB_DEPTH derivation and the entry field widths (rd_id 5, value 32, target 32), so the same values serve the register file, RS and LSB.
REQ-030 Single module; no sub-module. The entry array is flat per-field registers, and the query ports are pure muxes.

Verification
REQ-031 Issue rd=5, CDB tag0 value 0x1234 -> two cycles later rob_commit_signal=1, commit_rd_id=5, commit_rd_tag=0, commit_rd_value=0x1234.
REQ-032 Issue 16 entries -> rob_full=1; a 17th issue is ignored and tail stays 0; after one commit, rob_full=0.
REQ-033 Issue branch (rd=0) and then rd=3; CDB branch mispredict with target 0x100 -> clear_signal=1, redirect_pc=0x100, rob_commit_signal=0; next issue_tag=0.
REQ-034 CDB for tag 1 arrives before tag 0 -> commits occur in order tag0 then tag1, on consecutive cycles.
REQ-035 query_tag_1=2 while cdb_signal carries tag 2 value 0xBEEF -> query_ready_1=1, query_value_1=0xBEEF in the same cycle.
REQ-036 Hold rdy_in low for 3 cycles with the head ready -> no commit occurs; the commit happens on the first edge after rdy_in returns high.
